// File: rtl/psr_pkg.sv
// Purpose: shared defaults and flag bit positions for the processor status register stack.
// Latency: n/a (constants only).
// Backpressure: n/a.
package psr_pkg;
    localparam int PSR_WIDTH_DEF = 16;
    localparam int PSR_DEPTH_DEF = 4;

    // Flag bit positions inside the status word
    localparam int FLAG_C = 0;
    localparam int FLAG_L = 2;
    localparam int FLAG_F = 5;
    localparam int FLAG_Z = 6;
    localparam int FLAG_N = 7;
endpackage

// File: rtl/psr_lifo.sv
// Purpose: saved-flag LIFO (storage + occupancy counter) for psr_stack.
// Latency: push/pop take effect on the next rising clk edge; dout/full/empty decode registered state.
// Backpressure: none; push when full and pop when empty are dropped, push+pop together is a no-op.
// Ports: clk, reset (async active-low), push, pop, din -> dout (top-of-stack), level, full, empty.
module psr_lifo
    import psr_pkg::*;
#(
    parameter  int WIDTH = PSR_WIDTH_DEF,
    parameter  int DEPTH = PSR_DEPTH_DEF,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] stack [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    // Simultaneous push and pop cancel out: nothing moves.
    assign do_push = push && !pop && !full;
    assign do_pop  = pop && !push && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            if (do_push) begin
                level <= level + LW'(1);
            end else if (do_pop) begin
                level <= level - LW'(1);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && (level == LW'(i))) begin
                    stack[i] <= din;
                end
            end
        end
    end

    // Top of stack is entry level-1; reads zero when empty.
    always_comb begin
        dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (level == LW'(i + 1)) begin
                dout = stack[i];
            end
        end
    end
endmodule

// File: rtl/psr_stack.sv
// Purpose: processor status register with masked update and a save/restore stack for calls/interrupts.
// Latency: 1 cycle; read_flags/level/errors reflect the edge that caused them.
// Backpressure: none; push-when-full raises overflow, pop-when-empty raises underflow, op is dropped.
// Ports: clk, reset (async active-low), flags_in/flag_we (masked write), push, pop, err_clr ->
//        read_flags, level, full, empty, overflow, underflow.
// Config: define PSR_STICKY_ERR_EN for sticky error flags cleared by err_clr; otherwise one-cycle pulses.
module psr_stack
    import psr_pkg::*;
#(
    parameter  int WIDTH = PSR_WIDTH_DEF,
    parameter  int DEPTH = PSR_DEPTH_DEF,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] flags_in,
    input  logic [WIDTH-1:0] flag_we,
    input  logic             push,
    input  logic             pop,
    input  logic             err_clr,
    output logic [WIDTH-1:0] read_flags,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] cur_nxt;
    logic [WIDTH-1:0] top;
    logic             restore;
    logic             ovf_evt;
    logic             unf_evt;

    psr_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (cur),
        .dout  (top),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign restore = pop && !push && !empty;
    assign ovf_evt = push && !pop && full;
    assign unf_evt = pop && !push && empty;

    // A successful restore overrides the masked write for that cycle.
    always_comb begin
        cur_nxt = (cur & ~flag_we) | (flags_in & flag_we);
        if (restore) begin
            cur_nxt = top;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur <= '0;
        end else begin
            cur <= cur_nxt;
        end
    end

    assign read_flags = cur;

`ifdef PSR_STICKY_ERR_EN
    // New error beats err_clr in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (unf_evt) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_evt;
            underflow <= unf_evt;
        end
    end
`endif
endmodule

// File: tb/tb_psr_stack.sv
module tb_psr_stack;
    import psr_pkg::*;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int LW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  flags_in = '0;
    logic [W-1:0]  flag_we = '0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          err_clr = 1'b0;
    logic [W-1:0]  read_flags;
    logic [LW-1:0] level;
    logic          full, empty, overflow, underflow;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    psr_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .flags_in   (flags_in),
        .flag_we    (flag_we),
        .push       (push),
        .pop        (pop),
        .err_clr    (err_clr),
        .read_flags (read_flags),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue of saved words plus the current word.
    logic [W-1:0] m_cur = '0;
    logic [W-1:0] m_stk [$];
    bit           m_ovf = 1'b0;
    bit           m_unf = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cur = '0;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            bit oe, ue;
            oe = push && !pop && (m_stk.size() == D);
            ue = pop && !push && (m_stk.size() == 0);
            if (pop && !push && m_stk.size() > 0) begin
                m_cur = m_stk.pop_back();
            end else begin
                if (push && !pop && m_stk.size() < D) m_stk.push_back(m_cur);
                m_cur = (m_cur & ~flag_we) | (flags_in & flag_we);
            end
`ifdef PSR_STICKY_ERR_EN
            m_ovf = oe ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
            m_unf = ue ? 1'b1 : (err_clr ? 1'b0 : m_unf);
`else
            m_ovf = oe;
            m_unf = ue;
`endif
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_flags", 32'(read_flags), 32'(m_cur));
            check("m_level", 32'(level), 32'(m_stk.size()));
            check("m_full", 32'(full), 32'(m_stk.size() == D));
            check("m_empty", 32'(empty), 32'(m_stk.size() == 0));
            check("m_ovf", 32'(overflow), 32'(m_ovf));
            check("m_unf", 32'(underflow), 32'(m_unf));
        end
    end

    task automatic step(input logic [W-1:0] fin, input logic [W-1:0] we,
                        input logic pu, input logic po, input logic ec);
        @(negedge clk);
        flags_in = fin;
        flag_we  = we;
        push     = pu;
        pop      = po;
        err_clr  = ec;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] zc;
        zc = '0;
        zc[FLAG_Z] = 1'b1;
        zc[FLAG_C] = 1'b1;

        #12;
        check("rst_flags", 32'(read_flags), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        cmp_en = 1'b1;

        // Masked write then hold
        step(16'hFFFF, zc, 0, 0, 0);
        check("mask_write", 32'(read_flags), 32'h0041);
        step(16'hFFFF, 16'h0000, 0, 0, 0);
        check("mask_hold", 32'(read_flags), 32'h0041);

        // Push/pop save-restore
        step(16'h00C1, 16'hFFFF, 0, 0, 0);
        step(16'h0000, 16'h00FF, 1, 0, 0);
        check("push_flags", 32'(read_flags), 32'h0);
        check("push_level", 32'(level), 32'h1);
        step(16'hFFFF, 16'hFFFF, 0, 1, 0);
        check("pop_flags", 32'(read_flags), 32'h00C1);
        check("pop_level", 32'(level), 32'h0);
        check("pop_empty", 32'(empty), 32'h1);

        // Fill to depth and beyond: stack holds 1..4, fifth push (value 5) overflows
        step(16'h0001, 16'hFFFF, 0, 0, 0);
        for (int i = 2; i <= 5; i++) step(W'(i), 16'hFFFF, 1, 0, 0);
        check("fill_level", 32'(level), 32'h4);
        check("fill_full", 32'(full), 32'h1);
        check("fill_ovf0", 32'(overflow), 32'h0);
        step(16'h0006, 16'hFFFF, 1, 0, 0);
        check("ovf_set", 32'(overflow), 32'h1);
        check("ovf_level", 32'(level), 32'h4);
        check("ovf_flags", 32'(read_flags), 32'h0006);
        for (int i = 4; i >= 1; i--) begin
            step(16'hFFFF, 16'hFFFF, 0, 1, 0);
            check("lifo_order", 32'(read_flags), 32'(i));
        end
        check("drain_empty", 32'(empty), 32'h1);

        // Underflow behaviour and err_clr priority
        step(16'h0000, 16'h0000, 0, 1, 0);
        check("unf_set", 32'(underflow), 32'h1);
        check("unf_level", 32'(level), 32'h0);
        check("unf_flags", 32'(read_flags), 32'h0001);
        step(16'h0000, 16'h0000, 0, 0, 0);
`ifdef PSR_STICKY_ERR_EN
        check("unf_sticky", 32'(underflow), 32'h1);
`else
        check("unf_pulse", 32'(underflow), 32'h0);
`endif
        step(16'h0000, 16'h0000, 0, 0, 1);
        check("unf_clr", 32'(underflow), 32'h0);
        check("ovf_clr", 32'(overflow), 32'h0);
        step(16'h0000, 16'h0000, 0, 1, 1);
        check("unf_beats_clr", 32'(underflow), 32'h1);
        step(16'h0000, 16'h0000, 0, 0, 1);
        check("unf_clr2", 32'(underflow), 32'h0);

        // Simultaneous push+pop at level 2
        step(16'h00A0, 16'hFFFF, 0, 0, 0);
        step(16'h0000, 16'h0000, 1, 0, 0);
        step(16'h0000, 16'h0000, 1, 0, 0);
        check("pp_pre_level", 32'(level), 32'h2);
        step(16'h0001, 16'h0001, 1, 1, 0);
        check("pp_level", 32'(level), 32'h2);
        check("pp_flags", 32'(read_flags), 32'h00A1);
        check("pp_ovf", 32'(overflow), 32'h0);
        check("pp_unf", 32'(underflow), 32'h0);

        // Asynchronous reset between edges during a push at level 3
        step(16'h0000, 16'h0000, 1, 0, 0);
        check("pre_rst_level", 32'(level), 32'h3);
        @(negedge clk);
        flags_in = 16'h1234;
        flag_we  = 16'hFFFF;
        push     = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("arst_flags", 32'(read_flags), 32'h0);
        check("arst_level", 32'(level), 32'h0);
        check("arst_empty", 32'(empty), 32'h1);
        check("arst_full", 32'(full), 32'h0);
        check("arst_errs", 32'({overflow, underflow}), 32'h0);
        push    = 1'b0;
        flag_we = 16'h0000;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_level", 32'(level), 32'h0);

        // First operations after reset behave normally
        step(16'h0055, 16'hFFFF, 1, 0, 0);
        check("post_push_level", 32'(level), 32'h1);
        check("post_push_flags", 32'(read_flags), 32'h0055);
        step(16'h0000, 16'h0000, 0, 1, 0);
        check("post_pop_flags", 32'(read_flags), 32'h0);
        step(16'h0000, 16'h0000, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/psr_stack.md
PSR_STACK -- requirements
Module: psr_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning flag word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of saved-flag stack entries (>=1).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 flags_in  input  WIDTH  new flag values from ALU.
REQ-006 flag_we  input  WIDTH  per-bit write mask; 1 = update that flag.
REQ-007 push  input  1  save current flags to stack (interrupt/call entry).
REQ-008 pop  input  1  restore flags from stack (return).
REQ-009 err_clr  input  1  clear error outputs.
REQ-010 read_flags  output  WIDTH  current flag register.
REQ-011 level  output  $clog2(DEPTH+1)  number of occupied stack entries.
REQ-012 full, empty  output  1 each  level==DEPTH, level==0.
REQ-013 overflow, underflow  output  1 each  push-when-full, pop-when-empty indications.

Function
REQ-014 read_flags SHALL be the registered current value cur; updates visible the cycle after the triggering edge.
REQ-015 Normal cycle (no push, no pop): cur <= (cur & ~flag_we) | (flags_in & flag_we); flag_we==0 holds cur.
REQ-016 push with !full: stack[level] <= cur value before this edge; level+1; masked write of REQ-015 applies to cur in the same cycle.
REQ-017 pop with !empty: cur <= stack[level-1]; level-1; flag_we ignored that cycle (restore wins).
REQ-018 push and pop in the same cycle: stack and level unchanged, no error, masked write applies.
REQ-019 push with full: stack and level unchanged, overflow raised, masked write still applies.
REQ-020 pop with empty: cur unchanged except masked write, level stays 0, underflow raised.
REQ-021 full and empty SHALL be combinational decodes of registered level; level never wraps.
REQ-022 err_clr SHALL clear overflow/underflow; a new error in the same cycle as err_clr SHALL win (error set).

Reset
REQ-023 reset low SHALL immediately force cur=0, level=0, all stack entries=0, overflow=underflow=0; empty=1, full=0.
REQ-024 reset asserted mid push/pop SHALL discard the operation; first post-reset edge behaves per Function.

Configuration
REQ-025 Macro PSR_STICKY_ERR_EN defined: overflow/underflow SHALL be sticky until err_clr or reset.
REQ-026 Macro PSR_STICKY_ERR_EN undefined: overflow/underflow SHALL be one-cycle registered pulses; err_clr has no effect.

Structure
REQ-027 Package psr_pkg SHALL hold PSR_WIDTH_DEF=16, PSR_DEPTH_DEF=4, and flag bit index constants FLAG_C=0, FLAG_L=2, FLAG_F=5, FLAG_Z=6, FLAG_N=7.
REQ-028 Stack storage and level counter SHALL be a sub-module psr_lifo (push, pop, din, dout, level); psr_stack holds cur, mask merge and error logic.

Verification
REQ-029 Reset, flags_in=16'hFFFF, flag_we=16'h0041, one edge -> read_flags=16'h0041; then flag_we=0 -> holds 16'h0041.
REQ-030 cur=16'h00C1, push with flags_in=0, flag_we=16'h00FF -> read_flags=0, level=1; pop -> read_flags=16'h00C1, level=0, empty=1.
REQ-031 DEPTH=4: five pushes of distinct values 1..5 -> level=4, full=1, overflow set on 5th; four pops return 4,3,2,1 in order.
REQ-032 Pop while empty -> underflow=1, level=0; with PSR_STICKY_ERR_EN stays 1 until err_clr; without, 1 for exactly one cycle.
REQ-033 level=2, push and pop together with flag_we=16'h0001, flags_in=1 -> level=2, bit0 set, no error.
REQ-034 reset pulsed low between clock edges during push at level=3 -> all outputs return to reset values without waiting for clk.
